// File: rtl/packet_pkg.sv
// Shared types and helpers for the 4-port switch output scheduler.
package packet_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    O_IDLE  = 2'd0,
    O_GRANT = 2'd1,
    O_VALID = 2'd2
  } out_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } onehot_t;

  // Decode a one-hot destination mask; valid=0 for zero or multi-hot masks.
  function automatic onehot_t onehot_idx(input logic [N_PORTS-1:0] v);
    onehot_t r;
    r.valid = 1'b1;
    r.idx   = '0;
    case (v)
      4'b0001: r.idx = 2'd0;
      4'b0010: r.idx = 2'd1;
      4'b0100: r.idx = 2'd2;
      4'b1000: r.idx = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/switch_out_arbiter_rr.sv
// Combinational 4-way round-robin picker starting the search at ptr.
module rr_arbiter4
  import packet_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [3:0]       gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (en && !any && req[ptr + IDX_W'(k)]) begin
        any                     = 1'b1;
        gnt_idx                 = ptr + IDX_W'(k);
        gnt[ptr + IDX_W'(k)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Per-output round-robin scheduler and crossbar: grants inputs, captures the
// granted packet into each output register and hands it off via valid/ready.
module switch_out_arbiter
  import packet_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS*N_PORTS-1:0]  dst,
  input  logic [N_PORTS*DATA_W-1:0]   pkt_data,
  output logic [N_PORTS-1:0]          grant,
  output logic [N_PORTS-1:0]          err_drop,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  output logic [N_PORTS*IDX_W-1:0]    out_src,
  output logic [N_PORTS-1:0]          out_valid,
  input  logic [N_PORTS-1:0]          out_ready
);

  logic                        r_arm;
  logic [N_PORTS-1:0]          r_grant;
  logic [N_PORTS-1:0]          r_err;
  logic [N_PORTS-1:0]          r_out_valid;
  logic [N_PORTS*DATA_W-1:0]   r_out_data;
  logic [N_PORTS*IDX_W-1:0]    r_out_src;
  logic [IDX_W-1:0]            r_ptr   [N_PORTS];
  logic [IDX_W-1:0]            r_cap   [N_PORTS];
  out_state_t                  r_state [N_PORTS];

  onehot_t                     w_dec      [N_PORTS];
  logic [N_PORTS-1:0]          w_elig;
  logic [N_PORTS-1:0]          w_bad;
  logic [N_PORTS-1:0]          w_avail;
  logic [N_PORTS-1:0]          w_cont     [N_PORTS];
  logic [N_PORTS-1:0]          w_gnt      [N_PORTS];
  logic [IDX_W-1:0]            w_gnt_idx  [N_PORTS];
  logic [N_PORTS-1:0]          w_any;
  logic [N_PORTS-1:0]          w_grant_nxt;
  logic [N_PORTS-1:0]          w_err_nxt;
  logic [IDX_W-1:0]            w_ptr_nxt  [N_PORTS];
  logic [IDX_W-1:0]            w_cap_nxt  [N_PORTS];
  out_state_t                  w_state_nxt[N_PORTS];

  // Eligibility masks out the input being popped this cycle and the first cycle after reset.
  always_comb begin
    w_elig  = '0;
    w_bad   = '0;
    w_avail = '0;
    for (int o = 0; o < N_PORTS; o++) w_cont[o] = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_dec[i]  = onehot_idx(dst[i*N_PORTS +: N_PORTS]);
      w_elig[i] = req[i] & ~r_grant[i] & r_arm;
      w_bad[i]  = w_elig[i] & ~w_dec[i].valid;
      for (int o = 0; o < N_PORTS; o++) begin
        if (w_elig[i] && w_dec[i].valid && (w_dec[i].idx == IDX_W'(o)))
          w_cont[o][i] = 1'b1;
      end
    end
    for (int o = 0; o < N_PORTS; o++)
      w_avail[o] = (r_state[o] == O_IDLE) || ((r_state[o] == O_VALID) && out_ready[o]);
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    rr_arbiter4 u_arb (
      .req     (w_cont[g]),
      .ptr     (r_ptr[g]),
      .en      (w_avail[g]),
      .gnt     (w_gnt[g]),
      .gnt_idx (w_gnt_idx[g]),
      .any     (w_any[g])
    );
  end

  // Output FSMs, pointer update and grant merge; bad-dst requests are popped with err_drop.
  always_comb begin
    w_grant_nxt = w_bad;
    w_err_nxt   = w_bad;
    for (int o = 0; o < N_PORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_ptr_nxt[o]   = r_ptr[o];
      w_cap_nxt[o]   = r_cap[o];
      case (r_state[o])
        O_IDLE:  if (w_any[o]) w_state_nxt[o] = O_GRANT;
        O_GRANT: w_state_nxt[o] = O_VALID;
        O_VALID: if (out_ready[o]) w_state_nxt[o] = w_any[o] ? O_GRANT : O_IDLE;
        default: w_state_nxt[o] = O_IDLE;
      endcase
      if (w_any[o]) begin
        w_grant_nxt  = w_grant_nxt | w_gnt[o];
        w_ptr_nxt[o] = w_gnt_idx[o] + IDX_W'(1);
        w_cap_nxt[o] = w_gnt_idx[o];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm       <= 1'b0;
      r_grant     <= '0;
      r_err       <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        r_ptr[o]   <= '0;
        r_cap[o]   <= '0;
        r_state[o] <= O_IDLE;
      end
    end else begin
      r_arm   <= 1'b1;
      r_grant <= w_grant_nxt;
      r_err   <= w_err_nxt;
      for (int o = 0; o < N_PORTS; o++) begin
        r_ptr[o]       <= w_ptr_nxt[o];
        r_cap[o]       <= w_cap_nxt[o];
        r_state[o]     <= w_state_nxt[o];
        r_out_valid[o] <= (w_state_nxt[o] == O_VALID);
        // The winning input is popping this cycle, so its FIFO head is still valid.
        if (r_state[o] == O_GRANT) begin
          r_out_data[o*DATA_W +: DATA_W] <= pkt_data[r_cap[o]*DATA_W +: DATA_W];
          r_out_src[o*IDX_W +: IDX_W]    <= r_cap[o];
        end
      end
    end
  end

  assign grant     = r_grant;
  assign err_drop  = r_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed self-checking bench for switch_out_arbiter.
module tb_switch_out_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] dst;
  logic [63:0] pkt_data;
  logic [3:0]  grant;
  logic [3:0]  err_drop;
  logic [63:0] out_data;
  logic [7:0]  out_src;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Contention on output 1, cycles c1..c7 after the first request.
  logic [3:0]  c_grant [7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic        c_valid [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  c_src   [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
  logic [15:0] c_data  [7] = '{16'h0, 16'h1100, 16'h0, 16'h2211, 16'h0, 16'h4413, 16'h0};

  switch_out_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dst       (dst),
    .pkt_data  (pkt_data),
    .grant     (grant),
    .err_drop  (err_drop),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] od(input int o);
    return out_data[o*16 +: 16];
  endfunction

  function automatic logic [1:0] os(input int o);
    return out_src[o*2 +: 2];
  endfunction

  initial begin
    rst_n = 1'b0; req = '0; dst = '0; pkt_data = '0; out_ready = '0;
    repeat (2) tick();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_err", 64'(err_drop), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_data", out_data, 64'h0);
    check("rst_src", 64'(out_src), 64'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request input0 -> output2
    dst[3:0] = 4'b0100; pkt_data[15:0] = 16'h5A21; req = 4'b0001;
    tick();
    check("single_grant", 64'(grant), 64'h1);
    check("single_err", 64'(err_drop), 64'h0);
    check("single_valid_t1", 64'(out_valid), 64'h0);
    req = '0;
    tick();
    pkt_data[15:0] = 16'hFFFF;
    check("single_grant_t2", 64'(grant), 64'h0);
    check("single_valid_t2", 64'(out_valid), 64'b0100);
    check("single_data", 64'(od(2)), 64'h5A21);
    check("single_src", 64'(os(2)), 64'h0);
    out_ready = 4'b0100;
    tick();
    check("single_drain", 64'(out_valid), 64'h0);
    out_ready = '0;

    // Bad destinations on input1
    dst[7:4] = 4'b0110; req = 4'b0010;
    tick();
    check("bad_grant", 64'(grant), 64'b0010);
    check("bad_err", 64'(err_drop), 64'b0010);
    dst[7:4] = 4'b0000;
    tick();
    check("bad_masked", 64'(grant), 64'h0);
    check("bad_valid", 64'(out_valid), 64'h0);
    tick();
    check("bad0_grant", 64'(grant), 64'b0010);
    check("bad0_err", 64'(err_drop), 64'b0010);
    req = '0;
    tick();
    check("bad_valid2", 64'(out_valid), 64'h0);
    check("bad_err_clr", 64'(err_drop), 64'h0);

    // Contention: inputs 0,1,3 -> output1, ready high
    dst = 16'h2022; pkt_data = 64'h4413_0000_2211_1100;
    out_ready = 4'b1111; req = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("cont_grant_c%0d", k+1), 64'(grant), 64'(c_grant[k]));
      check($sformatf("cont_valid_c%0d", k+1), 64'(out_valid[1]), 64'(c_valid[k]));
      if (c_valid[k]) begin
        check($sformatf("cont_src_c%0d", k+1), 64'(os(1)), 64'(c_src[k]));
        check($sformatf("cont_data_c%0d", k+1), 64'(od(1)), 64'(c_data[k]));
      end
    end
    req = '0;
    repeat (2) tick();
    check("cont_idle", 64'(out_valid), 64'h0);

    // Backpressure on output3 from input2
    out_ready = '0; dst = '0; dst[11:8] = 4'b1000; pkt_data = '0;
    pkt_data[47:32] = 16'hA342; req = 4'b0100;
    tick();
    check("bp_grant1", 64'(grant), 64'b0100);
    tick();
    pkt_data[47:32] = 16'hB342;
    check("bp_valid1", 64'(out_valid), 64'b1000);
    check("bp_data1", 64'(od(3)), 64'hA342);
    check("bp_nogrant0", 64'(grant), 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_stall_grant%0d", k), 64'(grant), 64'h0);
      check($sformatf("bp_stall_data%0d", k), 64'(od(3)), 64'hA342);
      check($sformatf("bp_stall_valid%0d", k), 64'(out_valid[3]), 64'h1);
    end
    out_ready[3] = 1'b1;
    tick();
    check("bp_grant2", 64'(grant), 64'b0100);
    check("bp_gap", 64'(out_valid[3]), 64'h0);
    req = '0; out_ready = '0;
    tick();
    check("bp_valid2", 64'(out_valid), 64'b1000);
    check("bp_data2", 64'(od(3)), 64'hB342);
    check("bp_src2", 64'(os(3)), 64'h2);
    out_ready = 4'b1000;
    tick();
    check("bp_drain", 64'(out_valid), 64'h0);
    out_ready = '0;

    // Parallel routes: input0 -> out1, input2 -> out3
    dst = '0; dst[3:0] = 4'b0010; dst[11:8] = 4'b1000;
    pkt_data = 64'h0000_C032_0000_D010; req = 4'b0101;
    tick();
    check("par_grant", 64'(grant), 64'b0101);
    req = '0;
    tick();
    check("par_valid", 64'(out_valid), 64'b1010);
    check("par_data1", 64'(od(1)), 64'hD010);
    check("par_data3", 64'(od(3)), 64'hC032);
    check("par_src3", 64'(os(3)), 64'h2);
    out_ready = 4'b1111;
    tick();
    check("par_drain", 64'(out_valid), 64'h0);
    out_ready = '0;

    // Reset mid-operation: output3 holding, output0 in O_GRANT (self-destination)
    dst = '0; dst[15:12] = 4'b1000; pkt_data = '0; pkt_data[63:48] = 16'h9933; req = 4'b1000;
    tick();
    req = '0;
    tick();
    check("rm_hold", 64'(out_valid), 64'b1000);
    dst[3:0] = 4'b0001; pkt_data[15:0] = 16'h7700; req = 4'b0001;
    tick();
    check("rm_grant", 64'(grant), 64'b0001);
    req = '0;
    rst_n = 1'b0;
    #1;
    check("rm_async_grant", 64'(grant), 64'h0);
    check("rm_async_valid", 64'(out_valid), 64'h0);
    check("rm_async_data", out_data, 64'h0);
    check("rm_async_src", 64'(out_src), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rm_quiet_grant%0d", k), 64'(grant), 64'h0);
      check($sformatf("rm_quiet_valid%0d", k), 64'(out_valid), 64'h0);
    end
    pkt_data[15:0] = 16'h7701; req = 4'b0001;
    tick();
    check("rm_fresh_grant", 64'(grant), 64'b0001);
    req = '0;
    tick();
    check("rm_fresh_valid", 64'(out_valid), 64'b0001);
    check("rm_fresh_data", 64'(od(0)), 64'h7701);
    check("rm_fresh_src", 64'(os(0)), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
